// File: rtl/latency_measure_ctrl_pkg.sv
// Shared constants for the latency measurement controller: register map,
// CTRL/STATUS bit positions, FSM encoding and trigger port width.
package latency_measure_ctrl_pkg;

  localparam int IN_W = 10;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_ACK      = 3'd4;
  localparam logic [2:0] ADDR_LATENCY  = 3'd5;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd6;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_MODE  = 2;

  localparam int STAT_DONE    = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_IRQ     = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/latency_measure_ctrl_pio_edge_detect.sv
// Two-flop synchronizer for asynchronous trigger lines followed by a
// single-cycle rising-edge detector on the synchronized value.
module pio_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign rise   = sync_q & ~prev_q;

endmodule

// File: rtl/latency_measure_ctrl.sv
// Avalon-MM slave that measures host interrupt-to-acknowledge latency,
// armed either immediately or by a masked rising edge on in_port.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no measurement, waiting for a start write
// ST_ARMED    | started; waiting for trigger (immediate or masked edge)
// ST_WAIT_ACK | irq asserted, counter running, waiting for ACK/timeout
// ST_DONE     | result in LATENCY; done or timeout flag set
module latency_measure_ctrl
  import latency_measure_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      address,
  input  logic            read,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  input  logic [IN_W-1:0] in_port,
  output logic            irq
);

  state_e state_q, state_d;

  logic [IN_W-1:0] synced, rise, hit_vec;
  logic [IN_W-1:0] mask_q, edge_cap_q;
  logic [31:0]     counter_q, latency_q, timeout_limit_q;
  logic            mode_q, done_q, timeout_q, irq_q;

  logic wr_ctrl, start, abort, ack, hit, timeout_hit;
  logic arm_go, enter_wait, ack_done, to_done, clr_irq;

  pio_edge_detect #(.WIDTH(IN_W)) u_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (in_port),
    .synced   (synced),
    .rise     (rise)
  );

  assign wr_ctrl     = write && (address == ADDR_CTRL);
  assign start       = wr_ctrl && writedata[CTRL_START];
  assign abort       = wr_ctrl && writedata[CTRL_ABORT];
  assign ack         = write && (address == ADDR_ACK);
  assign hit_vec     = rise & mask_q;
  assign hit         = |hit_vec;
  assign timeout_hit = (timeout_limit_q != 32'd0) && (counter_q == timeout_limit_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Abort takes priority over everything, including a start in the same write.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_ARMED;
        ST_ARMED:         if (!mode_q || hit) state_d = ST_WAIT_ACK;
        ST_WAIT_ACK:      if (ack || timeout_hit) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    arm_go     = 1'b0;
    enter_wait = 1'b0;
    ack_done   = 1'b0;
    to_done    = 1'b0;
    if (state_d == ST_ARMED && (state_q == ST_IDLE || state_q == ST_DONE))
      arm_go = 1'b1;
    if (state_q == ST_ARMED && state_d == ST_WAIT_ACK)
      enter_wait = 1'b1;
    if (state_q == ST_WAIT_ACK && state_d == ST_DONE) begin
      ack_done = ack;
      to_done  = !ack;
    end
    clr_irq = abort || ack_done || to_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      irq_q           <= 1'b0;
      counter_q       <= '0;
      latency_q       <= '0;
      timeout_limit_q <= '0;
      mask_q          <= '0;
      edge_cap_q      <= '0;
    end else begin
      if (write && address == ADDR_MASK)    mask_q          <= writedata[IN_W-1:0];
      if (write && address == ADDR_TIMEOUT) timeout_limit_q <= writedata;
      if (arm_go) begin
        mode_q     <= writedata[CTRL_MODE];
        done_q     <= 1'b0;
        timeout_q  <= 1'b0;
        edge_cap_q <= '0;
      end
      if (enter_wait) begin
        counter_q <= '0;
        irq_q     <= 1'b1;
        if (mode_q) edge_cap_q <= hit_vec;
      end else if (state_q == ST_WAIT_ACK) begin
        counter_q <= sat_inc(counter_q);
      end
      if (ack_done) begin
        latency_q <= counter_q;
        done_q    <= 1'b1;
      end
      if (to_done) begin
        latency_q <= timeout_limit_q;
        timeout_q <= 1'b1;
      end
      if (clr_irq) irq_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        ADDR_DATA:     readdata <= {{(32-IN_W){1'b0}}, synced};
        ADDR_MASK:     readdata <= {{(32-IN_W){1'b0}}, mask_q};
        ADDR_STATUS:   readdata <= {27'd0, irq_q, timeout_q, done_q, state_q};
        ADDR_LATENCY:  readdata <= latency_q;
        ADDR_TIMEOUT:  readdata <= timeout_limit_q;
        ADDR_EDGE_CAP: readdata <= {{(32-IN_W){1'b0}}, edge_cap_q};
        default:       readdata <= '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
